ble_setup_sequencer: RTL and testbench



---
 rtl/ble_setup_pkg.sv | 47 ++++
 rtl/ble_ok_matcher.sv | 41 ++++
 rtl/ble_setup_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ble_setup_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_setup_pkg.sv
// ble_setup_pkg
// Shared definitions for the HM-10 power-on setup sequencer: FSM state
// encoding, the AT command table with per-command lengths, the reply
// characters, and small helpers for indexing the table.
// No ports (package).
package ble_setup_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LOAD    = 3'd1;
  localparam state_t S_SEND    = 3'd2;
  localparam state_t S_WAIT_OK = 3'd3;
  localparam state_t S_NEXT    = 3'd4;
  localparam state_t S_DONE    = 3'd5;
  localparam state_t S_FAIL    = 3'd6;

  localparam int CMD_MAX_LEN = 8;

  localparam logic [7:0] CHAR_O = 8'h4F;
  localparam logic [7:0] CHAR_K = 8'h4B;

  // Byte 0 of each entry is the first byte on the wire (leftmost character).
  localparam logic [0:7][0:7][7:0] CMD_ROM = '{
    {"AT", 48'h0},
    "AT+ROLE0",
    "AT+NOTI1",
    "AT+IMME0",
    {"AT", 48'h0},
    {"AT", 48'h0},
    {"AT", 48'h0},
    {"AT", 48'h0}
  };

  localparam logic [0:7][3:0] CMD_LEN = '{
    4'd2, 4'd8, 4'd8, 4'd8, 4'd2, 4'd2, 4'd2, 4'd2
  };

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [2:0] ptr);
    return CMD_ROM[idx][ptr];
  endfunction

  function automatic logic is_last_byte(input logic [2:0] idx, input logic [2:0] ptr);
    return ({1'b0, ptr} == (CMD_LEN[idx] - 4'd1));
  endfunction

endpackage

// File: rtl/ble_ok_matcher.sv
// ble_ok_matcher
// Detects the two-byte reply "OK" on the UART RX byte stream. Only bytes
// seen while enabled are remembered, so stale characters received while a
// command is still being transmitted can never complete a match.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clear       forget the previous byte (start of a new reply window)
//   en          matcher active (sequencer is waiting for a reply)
//   rx_data     received byte
//   rx_valid    one-cycle strobe for rx_data
//   ok          combinational pulse: this byte is the "K" following an "O"
module ble_ok_matcher
  import ble_setup_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ok
);

  logic [7:0] prev_r;

  // Previous-byte history, updated only by bytes accepted while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 8'h00;
    end else if (clear) begin
      prev_r <= 8'h00;
    end else if (en && rx_valid) begin
      prev_r <= rx_data;
    end else begin
      prev_r <= prev_r;
    end
  end

  assign ok = en && rx_valid && (rx_data == CHAR_K) && (prev_r == CHAR_O);

endmodule

// File: rtl/ble_setup_sequencer.sv
// ble_setup_sequencer
// Power-on configuration of the HM-10 BLE module: sends each AT command of
// the table byte by byte over the TX handshake, waits for "OK" with a
// timeout and bounded retries, then flags setup_done (or setup_error).
// Optional build macro: BLE_SETUP_ABORT_EN adds an `abort` input that forces
// the FAIL state without ever breaking a pending TX handshake.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               pulse; starts/restarts from IDLE, DONE or FAIL
//   tx_data, tx_valid   byte to UART TX, held until tx_ready
//   tx_ready            UART TX accepts the byte
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   resp_timeout_count  cycles allowed for "OK" (0 = wait forever)
//   setup_busy          sequence in progress
//   setup_done          level, configuration complete
//   setup_error         level, retries exhausted (or aborted)
//   cmd_idx             current command; the failing one while in FAIL
module ble_setup_sequencer
  import ble_setup_pkg::*;
#(
  parameter int NUM_CMDS    = 4,
  parameter int MAX_RETRIES = 2,
  parameter int TIMER_W     = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic [TIMER_W-1:0] resp_timeout_count,
`ifdef BLE_SETUP_ABORT_EN
  input  logic               abort,
`endif
  output logic               setup_busy,
  output logic               setup_done,
  output logic               setup_error,
  output logic [2:0]         cmd_idx
);

  state_t             state_r;
  state_t             state_s;
  logic [2:0]         ptr_r;
  logic [2:0]         retry_r;
  logic [TIMER_W-1:0] timer_r;
  logic               abort_pend_r;
  logic               abort_s;
  logic               hs_s;
  logic               last_byte_s;
  logic               timeout_s;
  logic               ok_s;
  logic               match_clear_s;
  logic               match_en_s;

`ifdef BLE_SETUP_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign hs_s          = tx_valid && tx_ready;
  assign last_byte_s   = is_last_byte(cmd_idx, ptr_r);
  assign timeout_s     = (resp_timeout_count != {TIMER_W{1'b0}}) &&
                         (timer_r == (resp_timeout_count - TIMER_W'(1)));
  assign match_en_s    = (state_r == S_WAIT_OK);
  assign match_clear_s = (state_r == S_SEND) && hs_s && last_byte_s;

  ble_ok_matcher u_ok_matcher (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (match_clear_s),
    .en       (match_en_s),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ok       (ok_s)
  );

  // Next-state decision; abort only takes effect at a handshake while sending.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) state_s = S_LOAD;
        else       state_s = state_r;
      end
      S_LOAD: begin
        if (abort_s) state_s = S_FAIL;
        else         state_s = S_SEND;
      end
      S_SEND: begin
        if (hs_s && (abort_s || abort_pend_r)) state_s = S_FAIL;
        else if (hs_s && last_byte_s)           state_s = S_WAIT_OK;
        else                                    state_s = S_SEND;
      end
      S_WAIT_OK: begin
        // OK has priority over a timeout landing in the same cycle.
        if (abort_s)                             state_s = S_FAIL;
        else if (ok_s)                           state_s = S_NEXT;
        else if (timeout_s && (retry_r == 3'(MAX_RETRIES))) state_s = S_FAIL;
        else if (timeout_s)                      state_s = S_LOAD;
        else                                     state_s = S_WAIT_OK;
      end
      S_NEXT: begin
        if (abort_s)                             state_s = S_FAIL;
        else if (cmd_idx == 3'(NUM_CMDS - 1))    state_s = S_DONE;
        else                                     state_s = S_LOAD;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      ptr_r        <= 3'd0;
      retry_r      <= 3'd0;
      timer_r      <= {TIMER_W{1'b0}};
      abort_pend_r <= 1'b0;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      cmd_idx      <= 3'd0;
      setup_busy   <= 1'b0;
      setup_done   <= 1'b0;
      setup_error  <= 1'b0;
    end else begin
      state_r     <= state_s;
      setup_busy  <= !((state_s == S_IDLE) || (state_s == S_DONE) || (state_s == S_FAIL));
      setup_done  <= (state_s == S_DONE);
      setup_error <= (state_s == S_FAIL);
      case (state_r)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            cmd_idx      <= 3'd0;
            retry_r      <= 3'd0;
            abort_pend_r <= 1'b0;
          end
        end
        S_LOAD: begin
          ptr_r <= 3'd0;
          if (!abort_s) begin
            tx_data  <= cmd_byte(cmd_idx, 3'd0);
            tx_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort_s) abort_pend_r <= 1'b1;
          if (hs_s) begin
            ptr_r <= ptr_r + 3'd1;
            if (state_s == S_SEND) begin
              tx_data <= cmd_byte(cmd_idx, ptr_r + 3'd1);
            end else begin
              tx_valid <= 1'b0;
              timer_r  <= {TIMER_W{1'b0}};
            end
          end
        end
        S_WAIT_OK: begin
          timer_r <= timer_r + TIMER_W'(1);
          if (state_s == S_LOAD) retry_r <= retry_r + 3'd1;
        end
        S_NEXT: begin
          if (state_s == S_LOAD) begin
            cmd_idx <= cmd_idx + 3'd1;
            retry_r <= 3'd0;
          end
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ble_setup_sequencer.sv
module tb_ble_setup_sequencer;

  localparam int NUM_CMDS    = 4;
  localparam int MAX_RETRIES = 2;
  localparam int TIMER_W     = 24;

  localparam int R_OK    = 0;
  localparam int R_SPLIT = 1;
  localparam int R_EDGE  = 2;
  localparam int R_NONE  = 3;
  localparam int R_KONLY = 4;
  localparam int R_STALE = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_valid = 1'b0;
  logic [TIMER_W-1:0] tmo = 24'd1000;
  logic               setup_busy;
  logic               setup_done;
  logic               setup_error;
  logic [2:0]         cmd_idx;
`ifdef BLE_SETUP_ABORT_EN
  logic               abort = 1'b0;
`endif

  ble_setup_sequencer #(.NUM_CMDS(NUM_CMDS), .MAX_RETRIES(MAX_RETRIES), .TIMER_W(TIMER_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .resp_timeout_count (tmo),
`ifdef BLE_SETUP_ABORT_EN
    .abort              (abort),
`endif
    .setup_busy         (setup_busy),
    .setup_done         (setup_done),
    .setup_error        (setup_error),
    .cmd_idx            (cmd_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_hs = 0;
  int last_rise = -1;
  int done_rise = -1;
  int err_rise = -1;
  bit ready_rand = 1'b0;
  bit ready_hold = 1'b0;
  logic [7:0] exp_q[$];

  logic       mon_pv = 1'b0;
  logic       mon_pr = 1'b0;
  logic [7:0] mon_pd = 8'h00;
  logic       mon_pdone = 1'b0;
  logic       mon_perr = 1'b0;

  string cmd_txt[4];
  int outc[$];
  int att_cum[$];
  int n_used;
  bit exp_done;
  bit exp_fail;
  int exp_idx;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: walk the outcome list by the sequencing rules.
  function automatic void run_model();
    int idx = 0;
    int r = 0;
    int cum = 0;
    att_cum.delete();
    n_used = 0;
    exp_done = 1'b0;
    exp_fail = 1'b0;
    for (int k = 0; k < outc.size(); k++) begin
      if (exp_done || exp_fail) break;
      cum += cmd_txt[idx].len();
      att_cum.push_back(cum);
      n_used++;
      if (outc[k] <= R_EDGE) begin
        if (idx == NUM_CMDS - 1) exp_done = 1'b1;
        else idx++;
        r = 0;
      end else begin
        if (r == MAX_RETRIES) exp_fail = 1'b1;
        else r++;
      end
    end
    exp_idx = idx;
  endfunction

  function automatic void push_expected();
    int idx = 0;
    int r = 0;
    for (int k = 0; k < n_used; k++) begin
      for (int j = 0; j < cmd_txt[idx].len(); j++) exp_q.push_back(cmd_txt[idx][j]);
      if (outc[k] <= R_EDGE) begin
        if (idx < NUM_CMDS - 1) idx++;
        r = 0;
      end else begin
        r++;
      end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = ready_hold ? 1'b0 : (ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1);
  end

  // Monitor / scoreboard: samples on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mon_pv = 1'b0;
      mon_pr = 1'b0;
      mon_pdone = 1'b0;
      mon_perr = 1'b0;
    end else begin
      if (tx_valid && !mon_pv) last_rise = cyc;
      if (setup_done && !mon_pdone) done_rise = cyc;
      if (setup_error && !mon_perr) err_rise = cyc;
      if (mon_pv && !mon_pr) begin
        chk("tx_valid_held", int'(tx_valid), 1);
        if (tx_valid) chk("tx_data_stable", int'(tx_data), int'(mon_pd));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_byte: got %0d expected no byte (cycle %0d)", tx_data, cyc);
        end else begin
          chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
        end
        hs_count++;
        last_hs = cyc;
      end
      mon_pv = tx_valid;
      mon_pr = tx_ready;
      mon_pd = tx_data;
      mon_pdone = setup_done;
      mon_perr = setup_error;
    end
  end

  task automatic send_rx(input logic [7:0] b, output int at);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_valid = 1'b1;
    at = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic rx_at(input int t, input logic [7:0] b);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (hs_count < target) chk("wait_tx_handshakes", hs_count, target);
  endtask

  task automatic wait_rise(input int after, input int bound);
    int n = 0;
    while (last_rise <= after && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk);
    #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", int'(setup_busy), 1);
    chk("start_clears_done", int'(setup_done), 0);
    chk("start_clears_error", int'(setup_error), 0);
  endtask

  task automatic run_scenario(input int t);
    int s;
    int h;
    int kc;
    int a;
    int hs0;
    int n;
    bit last;
    tmo = TIMER_W'(t);
    run_model();
    push_expected();
    hs0 = hs_count;
    done_rise = -1;
    err_rise = -1;
    kc = 0;
    h = 0;
    pulse_start(s);
    wait_rise(s, 20);
    chk("start_to_tx_valid", last_rise - s, 2);
    for (int k = 0; k < n_used; k++) begin
      last = (k == n_used - 1);
      if (outc[k] == R_STALE) begin
        wait_hs(hs0 + ((k == 0) ? 0 : att_cum[k-1]) + 1);
        ready_hold = 1'b1;
        send_rx("O", a);
        send_rx("K", a);
        ready_hold = 1'b0;
      end
      wait_hs(hs0 + att_cum[k]);
      h = last_hs;
      case (outc[k])
        R_OK: begin
          send_rx("O", a);
          send_rx("K", kc);
          send_rx(8'h0D, a);
          send_rx(8'h0A, a);
          if (!last) begin
            wait_rise(h, 50);
            chk("ok_to_next_tx_valid", last_rise - kc, 3);
          end
        end
        R_SPLIT: begin
          send_rx("O", a);
          rx_at(a + 6, "K");
          kc = a + 6;
        end
        R_EDGE: begin
          rx_at(h + 10, "O");
          rx_at(h + t, "K");
          kc = h + t;
        end
        R_KONLY: send_rx("K", a);
        default: a = 0;
      endcase
      if (outc[k] > R_EDGE && !last) begin
        wait_rise(h, t + 100);
        chk("resend_latency", last_rise - h, t + 2);
      end
    end
    n = 0;
    while (!setup_done && !setup_error && n < 4 * t + 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("setup_done", int'(setup_done), int'(exp_done));
    chk("setup_error", int'(setup_error), int'(exp_fail));
    chk("cmd_idx_final", int'(cmd_idx), exp_idx);
    chk("busy_final", int'(setup_busy), 0);
    if (exp_done) chk("ok_to_done_latency", done_rise - kc, 2);
    if (exp_fail) chk("timeout_to_fail_latency", err_rise - h, t + 1);
    chk("tx_bytes_remaining", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int s;
    int a;
    int rnd;
    cmd_txt[0] = "AT";
    cmd_txt[1] = "AT+ROLE0";
    cmd_txt[2] = "AT+NOTI1";
    cmd_txt[3] = "AT+IMME0";

    repeat (3) @(negedge clk);
    chk("reset_tx_valid", int'(tx_valid), 0);
    chk("reset_tx_data", int'(tx_data), 0);
    chk("reset_busy", int'(setup_busy), 0);
    chk("reset_done", int'(setup_done), 0);
    chk("reset_error", int'(setup_error), 0);
    chk("reset_cmd_idx", int'(cmd_idx), 0);
    rst_n = 1'b1;

    // Nominal run, then the same under TX backpressure.
    outc = {R_OK, R_OK, R_OK, R_OK};
    ready_rand = 1'b0;
    run_scenario(1000);
    ready_rand = 1'b1;
    run_scenario(1000);
    ready_rand = 1'b0;

    // One missed reply on AT+ROLE0, then success.
    outc = {R_OK, R_NONE, R_OK, R_OK, R_OK};
    run_scenario(50);

    // No replies at all: three attempts of AT, then FAIL on command 0.
    outc = {R_NONE, R_NONE, R_NONE};
    run_scenario(30);

    // Restart from FAIL with split, stale, lone-K and edge-of-timeout replies.
    outc = {R_SPLIT, R_STALE, R_KONLY, R_EDGE, R_OK, R_OK};
    run_scenario(50);

    // Reset while sending byte 4 of AT+NOTI1.
    tmo = 24'd1000;
    outc = {R_OK, R_OK, R_OK, R_OK};
    run_model();
    push_expected();
    a = hs_count;
    pulse_start(s);
    wait_hs(a + 2);
    send_rx("O", s);
    send_rx("K", s);
    wait_hs(a + 10);
    send_rx("O", s);
    send_rx("K", s);
    wait_hs(a + 14);
    @(posedge clk);
    #2;
    chk("pre_reset_tx_valid", int'(tx_valid), 1);
    chk("pre_reset_tx_data", int'(tx_data), int'(cmd_txt[2][4]));
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx_valid", int'(tx_valid), 0);
    chk("async_reset_tx_data", int'(tx_data), 0);
    chk("async_reset_busy", int'(setup_busy), 0);
    chk("async_reset_cmd_idx", int'(cmd_idx), 0);
    chk("abandoned_bytes", exp_q.size(), 12);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    run_scenario(1000);

    // Randomised outcomes and backpressure.
    for (int i = 0; i < 6; i++) begin
      ready_rand = ($urandom_range(0, 1) == 1);
      outc.delete();
      do begin
        rnd = $urandom_range(0, 9);
        outc.push_back(rnd < 4 ? R_OK : rnd < 5 ? R_SPLIT : rnd < 6 ? R_EDGE :
                       rnd < 8 ? R_NONE : R_KONLY);
        run_model();
      end while (!exp_done && !exp_fail);
      run_scenario(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
